// File: rtl/dcache_axi_bridge.sv
// dcache_axi_bridge
//   Responder end of the data-cache line refill / write-back interface.
//   One 8-word (32 B) line request from the dcache becomes a single AXI4
//   INCR burst on the memory bus. Completion is reported with a one-cycle
//   gnt pulse. err is valid with gnt.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   req_addr          line address from the cache, bits [4:0] ignored
//   rd_req / wr_req   line read / write request, held until gnt
//   wr_line           line to write, word i = bits [32i+31:32i]
//   rd_line           returned line, same packing, valid from gnt
//   gnt, err          completion pulse, error flag (any non-OKAY response)
//   ar*/r*            AXI read address / read data channels
//   aw*/w*/b*         AXI write address / write data / write response channels
//
// state | meaning
// IDLE  | waiting for a request; a write wins over a simultaneous read
// RADDR | arvalid high until arready
// RDATA | rready high, collecting 8 read beats into rd_line
// WADDR | awvalid high until awready
// WDATA | wvalid high, streaming line_q word by word
// WRESP | bready high until bvalid
// GRANT | gnt/err for one cycle, then back to IDLE
module dcache_axi_bridge #(
  parameter logic [3:0]  AXI_ID     = 4'd1,
  parameter int unsigned LINE_WORDS = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [31:0]  req_addr,
  input  logic         rd_req,
  input  logic         wr_req,
  input  logic [255:0] wr_line,
  output logic [255:0] rd_line,
  output logic         gnt,
  output logic         err,
  output logic [3:0]   arid,
  output logic [31:0]  araddr,
  output logic [7:0]   arlen,
  output logic [2:0]   arsize,
  output logic [1:0]   arburst,
  output logic         arvalid,
  input  logic         arready,
  input  logic [3:0]   rid,
  input  logic [31:0]  rdata,
  input  logic [1:0]   rresp,
  input  logic         rlast,
  input  logic         rvalid,
  output logic         rready,
  output logic [3:0]   awid,
  output logic [31:0]  awaddr,
  output logic [7:0]   awlen,
  output logic [2:0]   awsize,
  output logic [1:0]   awburst,
  output logic         awvalid,
  input  logic         awready,
  output logic [31:0]  wdata,
  output logic [3:0]   wstrb,
  output logic         wlast,
  output logic         wvalid,
  input  logic         wready,
  input  logic [3:0]   bid,
  input  logic [1:0]   bresp,
  input  logic         bvalid,
  output logic         bready
);

  localparam logic [7:0] BURST_LEN = 8'(LINE_WORDS - 1);
  localparam logic [2:0] LAST_CNT  = 3'(LINE_WORDS - 1);

  typedef enum logic [2:0] {
    IDLE, RADDR, RDATA, WADDR, WDATA, WRESP, GRANT
  } state_t;

  state_t       state, state_nxt;
  logic [26:0]  addr_q;
  logic [255:0] line_q;
  logic [255:0] rd_line_q;
  logic [2:0]   cnt;
  logic         err_q;

  // IDs are fixed and only one transaction is ever outstanding, so the
  // returned IDs carry no information.
  logic unused_inputs;
  assign unused_inputs = ^{rid, bid, req_addr[4:0]};

  assign arid    = AXI_ID;
  assign araddr  = {addr_q, 5'b0};
  assign arlen   = BURST_LEN;
  assign arsize  = 3'b010;
  assign arburst = 2'b01;
  assign awid    = AXI_ID;
  assign awaddr  = {addr_q, 5'b0};
  assign awlen   = BURST_LEN;
  assign awsize  = 3'b010;
  assign awburst = 2'b01;
  assign wstrb   = 4'hF;
  assign wdata   = line_q[{cnt, 5'd0} +: 32];
  assign rd_line = rd_line_q;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    arvalid   = 1'b0;
    rready    = 1'b0;
    awvalid   = 1'b0;
    wvalid    = 1'b0;
    wlast     = 1'b0;
    bready    = 1'b0;
    gnt       = 1'b0;
    err       = 1'b0;
    case (state)
      IDLE: begin
        if (wr_req)      state_nxt = WADDR;
        else if (rd_req) state_nxt = RADDR;
      end
      RADDR: begin
        arvalid = 1'b1;
        if (arready) state_nxt = RDATA;
      end
      RDATA: begin
        rready = 1'b1;
        // Either rlast or the beat count ends the burst; a slave that
        // forgets rlast cannot wedge the cache.
        if (rvalid && (rlast || cnt == LAST_CNT)) state_nxt = GRANT;
      end
      WADDR: begin
        awvalid = 1'b1;
        if (awready) state_nxt = WDATA;
      end
      WDATA: begin
        wvalid = 1'b1;
        wlast  = (cnt == LAST_CNT);
        if (wready && cnt == LAST_CNT) state_nxt = WRESP;
      end
      WRESP: begin
        bready = 1'b1;
        if (bvalid) state_nxt = GRANT;
      end
      GRANT: begin
        gnt       = 1'b1;
        err       = err_q;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q    <= '0;
      line_q    <= '0;
      rd_line_q <= '0;
      cnt       <= '0;
      err_q     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (wr_req) begin
            addr_q <= req_addr[31:5];
            line_q <= wr_line;
          end else if (rd_req) begin
            addr_q <= req_addr[31:5];
          end
        end
        RADDR: if (arready) cnt <= '0;
        RDATA: begin
          if (rvalid) begin
            rd_line_q[{cnt, 5'd0} +: 32] <= rdata;
            cnt <= cnt + 3'd1;
            if (rresp != 2'b00) err_q <= 1'b1;
          end
        end
        WADDR: if (awready) cnt <= '0;
        WDATA: if (wready) cnt <= cnt + 3'd1;
        WRESP: if (bvalid && bresp != 2'b00) err_q <= 1'b1;
        GRANT: err_q <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_axi_bridge.sv
`timescale 1ns/1ps
module tb_dcache_axi_bridge;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [31:0]  req_addr = '0;
  logic         rd_req = 1'b0;
  logic         wr_req = 1'b0;
  logic [255:0] wr_line = '0;
  logic [255:0] rd_line;
  logic         gnt, err;
  logic [3:0]   arid, awid, rid, bid;
  logic [31:0]  araddr, awaddr, rdata, wdata;
  logic [7:0]   arlen, awlen;
  logic [2:0]   arsize, awsize;
  logic [1:0]   arburst, awburst, rresp, bresp;
  logic         arvalid, arready, rlast, rvalid, rready;
  logic         awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic [3:0]   wstrb;

  dcache_axi_bridge dut (
    .clk(clk), .rst(rst), .req_addr(req_addr), .rd_req(rd_req), .wr_req(wr_req),
    .wr_line(wr_line), .rd_line(rd_line), .gnt(gnt), .err(err),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  function automatic void check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endfunction

  function automatic logic [255:0] make_line(input logic [31:0] base);
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = base + 32'(i);
    return l;
  endfunction

  // slave behaviour knobs
  int          ar_delay = 0, aw_delay = 0, b_delay = 0;
  logic [7:0]  r_stall = '0, w_stall = '0;
  logic [31:0] r_base = '0;
  logic [1:0]  r_resp_cfg = '0, b_resp_cfg = '0;

  // expectations for the transaction in flight
  logic [31:0]  exp_raddr = '0, exp_waddr = '0;
  logic [255:0] exp_wline = '0;

  // reference model state
  logic [255:0] m_line = '0;
  int           m_rbeat = 0, m_wbeat = 0, wlast_cnt = 0;
  bit           m_err = 0, gnt_due = 0, gnt_kind = 0, aw_done = 0, rst_edge = 1;
  bit           gnt_log[$];
  logic [31:0]  wseq[$];
  logic [31:0]  last_araddr = '0;
  logic [7:0]   last_arlen = '0;

  // AXI memory slave: reacts 2 ns after each rising edge
  initial begin : slave
    int ar_wait, aw_wait, b_wait, r_sent, w_recv;
    bit r_used, w_used, rst_seen;
    ar_wait = 0; aw_wait = 0; b_wait = 0; r_sent = 0; w_recv = 0;
    r_used = 0; w_used = 0; rst_seen = 1;
    arready = 0; rvalid = 0; rdata = '0; rresp = '0; rlast = 0; rid = '0;
    awready = 0; wready = 0; bvalid = 0; bresp = '0; bid = '0;
    forever begin
      @(posedge clk); #2;
      if (rst_seen) begin
        ar_wait = 0; aw_wait = 0; b_wait = 0; r_sent = 0; w_recv = 0; r_used = 0; w_used = 0;
      end else begin
        if (arready) begin ar_wait = 0; r_sent = 0; end
        if (rvalid)  begin r_sent++; r_used = 0; end
        if (awready) begin aw_wait = 0; w_recv = 0; end
        if (wready)  begin w_recv++; w_used = 0; end
        if (bvalid)  b_wait = 0;
      end
      rst_seen = rst;
      arready = 0; rvalid = 0; rlast = 0; awready = 0; wready = 0; bvalid = 0;
      if (!rst) begin
        if (arvalid) begin
          if (ar_wait >= ar_delay) arready = 1; else ar_wait++;
        end
        if (rready && r_sent < 8) begin
          if (r_stall[r_sent] && !r_used) r_used = 1;
          else begin
            rvalid = 1; rdata = r_base + 32'(r_sent); rresp = r_resp_cfg;
            rid = 4'd1; rlast = (r_sent == 7);
          end
        end
        if (awvalid) begin
          if (aw_wait >= aw_delay) awready = 1; else aw_wait++;
        end
        if (wvalid && w_recv < 8) begin
          if (w_stall[w_recv] && !w_used) w_used = 1;
          else wready = 1;
        end
        if (bready) begin
          if (b_wait >= b_delay) begin bvalid = 1; bresp = b_resp_cfg; bid = 4'd1; end
          else b_wait++;
        end
      end
    end
  end

  // compare process: outputs checked each falling edge, then handshakes
  // that will complete at the next rising edge are folded into the model
  always @(negedge clk) begin : monitor
    int act;
    if (rst_edge) begin
      check("idle after reset", {arvalid, rready, awvalid, wvalid, bready, gnt, err}, '0);
      check("rd_line after reset", rd_line, '0);
      m_line = '0; m_rbeat = 0; m_wbeat = 0; m_err = 0; gnt_due = 0; aw_done = 0;
    end else begin
      check("gnt", gnt, gnt_due);
      if (gnt_due) begin
        check("err", err, m_err);
        gnt_log.push_back(gnt_kind);
        m_err = 0; gnt_due = 0; aw_done = 0;
      end
      check("rd_line", rd_line, m_line);
      act = int'(arvalid) + int'(rready) + int'(awvalid) + int'(wvalid) + int'(bready);
      check("single channel", act <= 1, 1);
      if (arvalid) begin
        check("araddr", araddr, exp_raddr & ~32'h1F);
        check("ar fields", {arid, arlen, arsize, arburst}, {4'd1, 8'd7, 3'b010, 2'b01});
        check("ar during write", aw_done, 0);
      end
      if (awvalid) begin
        check("awaddr", awaddr, exp_waddr & ~32'h1F);
        check("aw fields", {awid, awlen, awsize, awburst}, {4'd1, 8'd7, 3'b010, 2'b01});
      end
      if (wvalid) begin
        check("w before aw", aw_done, 1);
        check("wdata", wdata, exp_wline[m_wbeat*32 +: 32]);
        check("wlast", wlast, m_wbeat == 7);
        check("wstrb", wstrb, 4'hF);
      end
      if (!rst) begin
        if (arvalid && arready) begin
          m_rbeat = 0; last_araddr = araddr; last_arlen = arlen;
        end
        if (rvalid && rready) begin
          m_line[m_rbeat*32 +: 32] = rdata;
          if (rresp != 2'b00) m_err = 1;
          if (rlast || m_rbeat == 7) begin gnt_due = 1; gnt_kind = 0; end
          m_rbeat++;
        end
        if (awvalid && awready) begin m_wbeat = 0; aw_done = 1; end
        if (wvalid && wready) begin
          wseq.push_back(wdata);
          if (wlast) wlast_cnt++;
          m_wbeat++;
        end
        if (bvalid && bready) begin
          if (bresp != 2'b00) m_err = 1;
          gnt_due = 1; gnt_kind = 1;
        end
      end
    end
    rst_edge = rst;
  end

  task automatic start_read(input logic [31:0] a);
    @(posedge clk); #1;
    exp_raddr = a; req_addr = a; rd_req = 1;
  endtask

  task automatic start_write(input logic [31:0] a, input logic [255:0] line);
    @(posedge clk); #1;
    exp_waddr = a; exp_wline = line; wr_line = line; req_addr = a; wr_req = 1;
  endtask

  // cycle 1 is the IDLE cycle in which the request is first visible
  task automatic wait_gnt(output int cyc);
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (!gnt && cyc < 100);
    check("gnt seen", gnt, 1);
  endtask

  task automatic end_req;
    @(posedge clk); #1;
    rd_req = 0; wr_req = 0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin : main
    int c, c2, n;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    check("reset gnt", gnt, 0);
    check("reset rd_line", rd_line, '0);

    // zero-wait read
    r_base = 32'hA0;
    start_read(32'h1FC0_0047);
    wait_gnt(c);
    check("read latency", c, 11);
    check("read err", err, 0);
    check("read line", rd_line,
          256'h000000A7_000000A6_000000A5_000000A4_000000A3_000000A2_000000A1_000000A0);
    check("araddr literal", last_araddr, 32'h1FC0_0040);
    check("arlen literal", last_arlen, 8'd7);
    end_req;

    // write with AW and W stalls
    aw_delay = 3; w_stall = 8'b0010_0100;
    wseq.delete(); wlast_cnt = 0;
    start_write(32'h0000_1020,
                256'h00000107_00000106_00000105_00000104_00000103_00000102_00000101_00000100);
    wait_gnt(c);
    check("stalled write latency", c, 17);
    check("write err", err, 0);
    end_req;
    check("wbeat count", wseq.size(), 8);
    for (int i = 0; i < 8; i++) check("wdata sequence", wseq[i], 32'h100 + 32'(i));
    check("wlast count", wlast_cnt, 1);

    // write-back then refill
    aw_delay = 0; w_stall = '0; b_delay = 1; r_base = 32'hB0;
    gnt_log.delete();
    start_write(32'h0000_3040, make_line(32'hDEAD_0000));
    wait_gnt(c);
    check("wb latency", c, 13);
    @(posedge clk); #1;
    wr_req = 0; exp_raddr = 32'h0000_5000; req_addr = 32'h0000_5000; rd_req = 1;
    wait_gnt(c2);
    check("refill latency", c2, 11);
    check("refill line", rd_line, make_line(32'hB0));
    end_req;
    check("b2b gnt count", gnt_log.size(), 2);
    check("b2b first write", gnt_log[0], 1);
    check("b2b second read", gnt_log[1], 0);

    // simultaneous requests: write first
    b_delay = 0; r_base = 32'h50;
    gnt_log.delete();
    @(posedge clk); #1;
    exp_raddr = 32'h0000_4000; exp_waddr = 32'h0000_4000;
    exp_wline = make_line(32'h4000); wr_line = exp_wline;
    req_addr = 32'h0000_4000; rd_req = 1; wr_req = 1;
    wait_gnt(c);
    check("simul write latency", c, 12);
    @(posedge clk); #1;
    wr_req = 0;
    wait_gnt(c2);
    check("simul read latency", c2, 11);
    check("simul read line", rd_line, make_line(32'h50));
    end_req;
    check("simul gnt count", gnt_log.size(), 2);
    check("simul first write", gnt_log[0], 1);
    check("simul second read", gnt_log[1], 0);

    // error response, then clean read
    b_resp_cfg = 2'b10;
    start_write(32'h0000_6000, make_line(32'h6000));
    wait_gnt(c);
    check("bresp err", err, 1);
    end_req;
    b_resp_cfg = 2'b00; r_base = 32'h60;
    start_read(32'h0000_6000);
    wait_gnt(c);
    check("clean read err", err, 0);
    end_req;

    // reset during an R burst
    r_base = 32'hE0;
    start_read(32'h0000_7000);
    n = 0;
    do begin @(negedge clk); #1; n++; end while (m_rbeat != 4 && n < 50);
    check("reached beat 4", m_rbeat, 4);
    @(posedge clk); #1;
    rst = 1; rd_req = 0;
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    check("mid reset outputs", {arvalid, rready, awvalid, wvalid, bready, gnt}, '0);
    check("mid reset rd_line", rd_line, '0);

    // fresh read after reset, with AR and R stalls
    ar_delay = 2; r_stall = 8'b1000_0001; r_base = 32'hF0;
    start_read(32'h0000_8000);
    wait_gnt(c);
    check("post reset latency", c, 15);
    check("post reset line", rd_line, make_line(32'hF0));
    check("post reset err", err, 0);
    end_req;
    repeat (3) @(posedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
